// File: rtl/lpddr2_avalon_bridge.sv
// lpddr2_avalon_bridge: CPU level-style requests to single-beat Avalon-MM with a one-entry read buffer
module lpddr2_avalon_bridge #(
  parameter int AW = 27,
  parameter int DW = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   address,
  input  logic [DW-1:0]   write_data,
  input  logic            read_req,
  input  logic            write_req,
  output logic [DW-1:0]   read_data,
  output logic            stall,
  output logic            err,
  input  logic            local_init_done,
  output logic [AW-1:0]   avl_addr,
  output logic [DW-1:0]   avl_wdata,
  output logic [DW/8-1:0] avl_be,
  output logic [2:0]      avl_size,
  output logic            avl_burstbegin,
  output logic            avl_read_req,
  output logic            avl_write_req,
  input  logic            avl_ready,
  input  logic [DW-1:0]   avl_rdata,
  input  logic            avl_rdata_valid
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT} state_t;
  state_t        state_q;
  logic          buf_valid_q;
  logic [AW-1:0] buf_tag_q;
  logic [DW-1:0] read_data_q;
  logic          err_q;
  logic [AW-1:0] avl_addr_q;
  logic [DW-1:0] avl_wdata_q;
  logic          avl_read_req_q;
  logic          avl_write_req_q;
  logic          avl_burstbegin_q;
  logic [CW-1:0] cnt_q;
  logic          hit;
  assign hit            = buf_valid_q && (buf_tag_q == address);
  assign stall          = !local_init_done || state_q != IDLE || write_req || (read_req && !hit);
  assign read_data      = read_data_q;
  assign err            = err_q;
  assign avl_addr       = avl_addr_q;
  assign avl_wdata      = avl_wdata_q;
  assign avl_be         = '1;
  assign avl_size       = 3'd1;
  assign avl_burstbegin = avl_burstbegin_q;
  assign avl_read_req   = avl_read_req_q;
  assign avl_write_req  = avl_write_req_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q          <= IDLE;
      buf_valid_q      <= 1'b0;
      buf_tag_q        <= '0;
      read_data_q      <= '0;
      err_q            <= 1'b0;
      avl_addr_q       <= '0;
      avl_wdata_q      <= '0;
      avl_read_req_q   <= 1'b0;
      avl_write_req_q  <= 1'b0;
      avl_burstbegin_q <= 1'b0;
      cnt_q            <= '0;
    end else begin
      avl_burstbegin_q <= 1'b0;
      case (state_q)
        IDLE:
          if (local_init_done) begin
            if (write_req) begin
              avl_addr_q       <= address;
              avl_wdata_q      <= write_data;
              avl_write_req_q  <= 1'b1;
              avl_burstbegin_q <= 1'b1;
              state_q          <= WR_ISSUE;
            end else if (read_req && !hit) begin
              avl_addr_q       <= address;
              avl_read_req_q   <= 1'b1;
              avl_burstbegin_q <= 1'b1;
              state_q          <= RD_ISSUE;
            end
          end
        WR_ISSUE:
          if (avl_ready) begin
            // write-through: the written word becomes the buffered word
            avl_write_req_q <= 1'b0;
            buf_tag_q       <= avl_addr_q;
            read_data_q     <= avl_wdata_q;
            buf_valid_q     <= 1'b1;
            state_q         <= IDLE;
          end
        RD_ISSUE:
          if (avl_ready) begin
            avl_read_req_q <= 1'b0;
            cnt_q          <= '0;
            state_q        <= RD_WAIT;
          end
        RD_WAIT:
          if (avl_rdata_valid) begin
            read_data_q <= avl_rdata;
            buf_tag_q   <= avl_addr_q;
            buf_valid_q <= 1'b1;
            state_q     <= IDLE;
          end else if (cnt_q == CW'(TIMEOUT)) begin
            // abandon the read; the still-held request reissues from IDLE
            err_q       <= 1'b1;
            buf_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_lpddr2_avalon_bridge.sv
// tb_lpddr2_avalon_bridge: directed checks of the LPDDR2 Avalon bridge
module tb_lpddr2_avalon_bridge;
  logic        clk = 0;
  logic        rst = 1;
  logic [26:0] address = '0;
  logic [31:0] write_data = '0;
  logic        read_req = 0, write_req = 0;
  logic [31:0] read_data;
  logic        stall, err;
  logic        local_init_done = 0;
  logic [26:0] avl_addr;
  logic [31:0] avl_wdata;
  logic [3:0]  avl_be;
  logic [2:0]  avl_size;
  logic        avl_burstbegin, avl_read_req, avl_write_req;
  logic        avl_ready = 0;
  logic [31:0] avl_rdata = '0;
  logic        avl_rdata_valid = 0;
  int tests = 0, fails = 0;
  int rd_cyc = 0, rd_acc = 0, wr_cyc = 0, wr_acc = 0, bb_cyc = 0, both = 0;
  int r0, w0, b0;

  lpddr2_avalon_bridge #(.AW(27), .DW(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data),
    .read_req(read_req), .write_req(write_req), .read_data(read_data),
    .stall(stall), .err(err), .local_init_done(local_init_done),
    .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_size(avl_size),
    .avl_burstbegin(avl_burstbegin), .avl_read_req(avl_read_req),
    .avl_write_req(avl_write_req), .avl_ready(avl_ready), .avl_rdata(avl_rdata),
    .avl_rdata_valid(avl_rdata_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (avl_read_req) rd_cyc++;
    if (avl_read_req && avl_ready) rd_acc++;
    if (avl_write_req) wr_cyc++;
    if (avl_write_req && avl_ready) wr_acc++;
    if (avl_burstbegin) bb_cyc++;
    if (avl_read_req && avl_write_req) both++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick(2);
    chk("rst_addr", avl_addr, 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_err", err, 0);
    chk("rst_rreq", avl_read_req, 0);
    chk("rst_wreq", avl_write_req, 0);
    chk("rst_bb", avl_burstbegin, 0);
    chk("const_be", avl_be, 4'hF);
    chk("const_size", avl_size, 1);
    rst = 0;
    // no init: request is stalled and not issued
    address = 27'h100; read_req = 1;
    tick(3);
    chk("noinit_stall", stall, 1);
    chk("noinit_rcyc", rd_cyc, 0);
    local_init_done = 1; avl_ready = 1;
    tick();
    chk("init_rreq", avl_read_req, 1);
    chk("init_bb", avl_burstbegin, 1);
    chk("init_addr", avl_addr, 27'h100);
    tick();
    avl_rdata_valid = 1; avl_rdata = 32'h11111111;
    tick();
    avl_rdata_valid = 0; #1;
    chk("init_data", read_data, 32'h11111111);
    chk("init_stall", stall, 0);
    chk("init_racc", rd_acc, 1);
    // read miss with 5-cycle controller latency, then held address hits
    r0 = rd_cyc; b0 = bb_cyc;
    address = 27'h0000800; #1;
    chk("miss_stall", stall, 1);
    tick(2);
    chk("miss_rcyc", rd_cyc - r0, 1);
    chk("miss_bb", bb_cyc - b0, 1);
    chk("miss_wait_stall", stall, 1);
    tick(4);
    avl_rdata_valid = 1; avl_rdata = 32'hDEADBEEF;
    tick();
    avl_rdata_valid = 0; #1;
    chk("miss_data", read_data, 32'hDEADBEEF);
    chk("miss_stall_done", stall, 0);
    tick(5);
    chk("hold_no_reread", rd_cyc - r0, 1);
    chk("hold_stall", stall, 0);
    // write with ready low for 3 cycles
    w0 = wr_cyc; b0 = bb_cyc;
    avl_ready = 0; read_req = 0; write_req = 1;
    address = 27'h0001000; write_data = 32'h12345678; #1;
    chk("wr_stall_idle", stall, 1);
    tick();
    write_req = 0; #1;
    chk("wr_stall_issue", stall, 1);
    chk("wr_addr", avl_addr, 27'h0001000);
    chk("wr_wdata", avl_wdata, 32'h12345678);
    tick(3);
    avl_ready = 1;
    tick();
    chk("wr_cycles", wr_cyc - w0, 4);
    chk("wr_bb", bb_cyc - b0, 1);
    chk("wr_acc", wr_acc, 1);
    chk("wr_done_wreq", avl_write_req, 0);
    chk("wr_done_stall", stall, 0);
    r0 = rd_cyc;
    read_req = 1; #1;
    chk("wr_hit_stall", stall, 0);
    chk("wr_hit_data", read_data, 32'h12345678);
    tick(3);
    chk("wr_hit_noread", rd_cyc - r0, 0);
    // write and read together: write goes first, then the read miss
    write_req = 1; address = 27'h2000; write_data = 32'hA5A5A5A5;
    tick();
    chk("both_wreq", avl_write_req, 1);
    chk("both_rreq_low", avl_read_req, 0);
    chk("both_waddr", avl_addr, 27'h2000);
    write_req = 0; address = 27'h3000;
    tick();
    chk("both_wacc", wr_acc, 2);
    chk("both_wdone", avl_write_req, 0);
    chk("both_stall", stall, 1);
    tick();
    chk("both_rreq", avl_read_req, 1);
    chk("both_raddr", avl_addr, 27'h3000);
    tick();
    avl_rdata_valid = 1; avl_rdata = 32'hCAFEF00D;
    tick();
    avl_rdata_valid = 0; #1;
    chk("both_rdata", read_data, 32'hCAFEF00D);
    chk("both_rstall", stall, 0);
    // timeout after 16 RD_WAIT cycles, then reissue
    r0 = rd_acc;
    address = 27'h4000;
    tick(2);
    tick(15);
    chk("to_err_before", err, 0);
    chk("to_stall_before", stall, 1);
    tick();
    chk("to_err", err, 1);
    chk("to_rreq_idle", avl_read_req, 0);
    chk("to_stall", stall, 1);
    tick();
    chk("to_reissue", avl_read_req, 1);
    chk("to_reissue_bb", avl_burstbegin, 1);
    chk("to_reissue_addr", avl_addr, 27'h4000);
    tick();
    chk("to_racc", rd_acc - r0, 2);
    avl_rdata_valid = 1; avl_rdata = 32'h55AA55AA;
    tick();
    avl_rdata_valid = 0; #1;
    chk("to_data", read_data, 32'h55AA55AA);
    chk("to_err_sticky", err, 1);
    chk("to_stall_done", stall, 0);
    // asynchronous reset during RD_WAIT
    address = 27'h5000;
    tick(5);
    rst = 1; #1;
    chk("arst_addr", avl_addr, 0);
    chk("arst_rdata", read_data, 0);
    chk("arst_err", err, 0);
    chk("arst_rreq", avl_read_req, 0);
    chk("arst_bb", avl_burstbegin, 0);
    chk("arst_stall", stall, 1);
    tick();
    rst = 0; read_req = 0;
    avl_rdata_valid = 1; avl_rdata = 32'h77777777;
    tick();
    avl_rdata_valid = 0; #1;
    chk("late_valid_data", read_data, 0);
    chk("late_valid_rreq", avl_read_req, 0);
    chk("late_valid_stall", stall, 0);
    read_req = 1; #1;
    chk("post_rst_miss", stall, 1);
    tick();
    chk("post_rst_rreq", avl_read_req, 1);
    chk("post_rst_addr", avl_addr, 27'h5000);
    chk("never_both", both, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lpddr2_avalon_bridge.md
Name: lpddr2_avalon_bridge

Overview:
Sits directly downstream of the CPU memory master's LPDDR2 port and converts its level-style read_req/write_req requests into single-beat Avalon-MM transactions on the LPDDR2 controller's local interface. It holds a one-entry read buffer, so a read request held steadily at one address issues exactly one controller read. It asserts stall to the CPU until each access completes. A read timeout watchdog raises a sticky error flag.

Parameters:
AW, 27, word address width (request and Avalon side)
DW, 32, data width
TIMEOUT, 1023, max cycles waiting in RD_WAIT before abort (counter width clog2(TIMEOUT+1))

Ports:
clk  in  1  system clock, same clock as the Avalon local interface
rst  in  1  asynchronous active-high reset
address  in  AW  word address from memory master
write_data  in  DW  write data from memory master
read_req  in  1  read request level; held while stall=1
write_req  in  1  write request level; held while stall=1; has priority over read_req
read_data  out  DW  read buffer contents
stall  out  1  CPU must hold its request and freeze
err  out  1  sticky read-timeout flag
local_init_done  in  1  controller calibration complete
avl_addr  out  AW  Avalon address
avl_wdata  out  DW  Avalon write data
avl_be  out  DW/8  byte enables, constant all ones
avl_size  out  3  burst size, constant 1
avl_burstbegin  out  1  first cycle of each new command
avl_read_req  out  1  Avalon read command
avl_write_req  out  1  Avalon write command
avl_ready  in  1  controller accepts a command when high together with a req
avl_rdata  in  DW  read data
avl_rdata_valid  in  1  read data strobe

Behaviour:
- States: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT.
- Reset values: state IDLE; buf_valid 0; buf_tag 0; read_data 0; err 0; all avl_* request strobes 0; avl_addr 0; avl_wdata 0; timeout counter 0.
- hit = buf_valid && (buf_tag == address).
- stall (combinational) = !local_init_done || state != IDLE || (state == IDLE && (write_req || (read_req && !hit))).
- IDLE, local_init_done = 0: no action.
- IDLE, write_req = 1: latch address into avl_addr and write_data into avl_wdata; go to WR_ISSUE.
- IDLE, read_req = 1, write_req = 0, not hit: latch address into avl_addr; go to RD_ISSUE.
- IDLE, read hit: no transaction; read_data already valid; stall = 0.
- WR_ISSUE:
  - avl_write_req = 1 until a cycle with avl_ready = 1.
  - avl_burstbegin = 1 only in the first cycle of WR_ISSUE.
  - On acceptance: buf_tag <= avl_addr, buffer data <= avl_wdata, buf_valid <= 1 (write-through fill); go to IDLE.
- RD_ISSUE:
  - avl_read_req = 1 until avl_ready = 1.
  - avl_burstbegin = 1 only in the first cycle of RD_ISSUE.
  - On acceptance: clear the timeout counter; go to RD_WAIT.
- RD_WAIT:
  - On avl_rdata_valid: read_data <= avl_rdata, buf_tag <= avl_addr, buf_valid <= 1; go to IDLE.
  - Stall drops the cycle after capture because the request now hits.
  - Otherwise increment the counter.
  - When counter == TIMEOUT: err <= 1, buf_valid <= 0, go to IDLE. The request stays unserviced and is reissued from IDLE.
- Timing: the request address and data are captured in IDLE only. Changes on the input ports while stall = 1 are ignored until the return to IDLE.
- Minimum latency, read miss: 1 cycle IDLE->RD_ISSUE, plus ready wait, plus controller read latency, plus 1 capture cycle.
- Minimum latency, write: 2 cycles when avl_ready is already high.
- Stray avl_rdata_valid outside RD_WAIT is ignored.
- Reset asserted mid-transaction returns the block to IDLE immediately. The buffer is invalidated, and no further req strobes are driven.
- avl_read_req and avl_write_req are never high in the same cycle.

Test Plan:
- Reset, then local_init_done = 0 with read_req = 1 -> stall = 1 and no avl_read_req. Raise init -> one read at that address.
- read_req held at address 0x0000800, controller returns 0xDEADBEEF after 5 cycles -> exactly one avl_read_req pulse with burstbegin. Then read_data = 0xDEADBEEF, stall = 0, and no further reads while the address is held.
- write_req to 0x0001000 with data 0x12345678, avl_ready held low 3 cycles -> avl_write_req high for 4 cycles and burstbegin for 1 cycle. A subsequent read of 0x0001000 hits with no Avalon read.
- write_req and read_req both high -> the write is issued first, then the read miss (different address) is issued.
- Read with avl_rdata_valid never asserted, TIMEOUT = 15 -> err = 1 after 16 RD_WAIT cycles, then the read is reissued. err stays 1 until rst.
- rst pulsed during RD_WAIT -> outputs return to reset values asynchronously. A late avl_rdata_valid is ignored and the next read misses.
